// File: rtl/sprite_pkg.sv
// Shared sizes, FSM states and the draw-command record for the sprite blitter.
package sprite_pkg;

    localparam int SPR_W  = 16;
    localparam int SPR_H  = 16;
    localparam int SCR_W  = 320;
    localparam int SCR_H  = 240;
    localparam int PIX_W  = 4;

    localparam int COL_W  = $clog2(SPR_W);
    localparam int ROW_W  = $clog2(SPR_H);
    localparam int CNT_W  = COL_W + ROW_W;
    localparam int ROM_AW = 2 + CNT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] plane;
        logic [1:0] id;
        logic [8:0] x;
        logic [8:0] y;
    } draw_cmd_t;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Command, sprite-ROM and frame-buffer signals of the blitter; master is the
// surrounding system, slave is the engine.
interface sprite_draw_engine_if;
    import sprite_pkg::*;

    logic              CMD_VALID;
    logic              CMD_READY;
    logic [1:0]        ADDR_IN;
    logic [1:0]        ID_CODE_IN;
    logic [8:0]        X_IN;
    logic [8:0]        Y_IN;
    logic              ROM_RE;
    logic [ROM_AW-1:0] ROM_ADDR;
    logic [PIX_W-1:0]  ROM_DATA;
    logic              FB_WE;
    logic              FB_READY;
    logic [1:0]        FB_PLANE;
    logic [8:0]        FB_X;
    logic [8:0]        FB_Y;
    logic [PIX_W-1:0]  FB_DATA;
    logic              BUSY;
    logic              DONE;

    modport master (
        output CMD_VALID, ADDR_IN, ID_CODE_IN, X_IN, Y_IN, ROM_DATA, FB_READY,
        input  CMD_READY, ROM_RE, ROM_ADDR, FB_WE, FB_PLANE, FB_X, FB_Y, FB_DATA,
               BUSY, DONE
    );

    modport slave (
        input  CMD_VALID, ADDR_IN, ID_CODE_IN, X_IN, Y_IN, ROM_DATA, FB_READY,
        output CMD_READY, ROM_RE, ROM_ADDR, FB_WE, FB_PLANE, FB_X, FB_Y, FB_DATA,
               BUSY, DONE
    );

endinterface

// File: rtl/sprite_addr_gen.sv
// Raster row/col counter for one sprite; ROM address is {id, row, col}.
module sprite_addr_gen
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [1:0]        i_id,
    output logic [ROW_W-1:0]  o_row,
    output logic [COL_W-1:0]  o_col,
    output logic              o_last,
    output logic [ROM_AW-1:0] o_addr
);

    // Power-of-two sizes let one counter carry col into row for free.
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (srst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_row  = r_cnt[CNT_W-1:COL_W];
    assign o_col  = r_cnt[COL_W-1:0];
    assign o_last = &r_cnt;
    assign o_addr = {i_id, r_cnt};

endmodule

// File: rtl/sprite_draw_engine.sv
// Blits one 16x16 sprite per command into the frame buffer, skipping index 0.
// Define SPRITE_CLIP_EN to discard pixels outside the visible screen.
module sprite_draw_engine
    import sprite_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_draw_engine_if.slave  bus
);

`ifdef SPRITE_CLIP_EN
    localparam int CW = 10;
`else
    localparam int CW = 9;
`endif

    state_t            r_state;
    state_t            w_state_next;
    draw_cmd_t         r_cmd;
    logic              r_wvalid;
    logic              r_done;
    logic [CW-1:0]     r_px;
    logic [CW-1:0]     r_py;

    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic              w_last;
    logic [ROM_AW-1:0] w_rom_addr;
    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_issue;
    logic              w_retire;
    logic              w_clip;
    logic              w_we;
    logic              w_stall;

    sprite_addr_gen u_addr_gen (
        .clk    (Clk),
        .srst   (Reset),
        .i_clr  (w_accept),
        .i_en   (w_issue),
        .i_id   (r_cmd.id),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last),
        .o_addr (w_rom_addr)
    );

`ifdef SPRITE_CLIP_EN
    assign w_clip = (r_px >= CW'(SCR_W)) || (r_py >= CW'(SCR_H));
`else
    assign w_clip = 1'b0;
`endif

    // Write slot uses the ROM word directly; ROM holds it while ROM_RE is low.
    assign w_we        = r_wvalid && (bus.ROM_DATA != '0) && !w_clip;
    assign w_stall     = w_we && !bus.FB_READY;
    assign w_cmd_ready = (r_state == IDLE) && !Reset;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.CMD_VALID && w_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!w_stall) begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!w_stall) begin
                    w_retire     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cmd    <= '0;
            r_wvalid <= 1'b0;
            r_done   <= 1'b0;
            r_px     <= '0;
            r_py     <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_retire;
            if (w_accept) begin
                r_cmd <= '{plane: bus.ADDR_IN, id: bus.ID_CODE_IN,
                           x: bus.X_IN, y: bus.Y_IN};
            end
            // Coordinates travel with the read so they line up with ROM_DATA.
            if (w_issue) begin
                r_wvalid <= 1'b1;
                r_px     <= CW'({1'b0, r_cmd.x}) + CW'(w_col);
                r_py     <= CW'({1'b0, r_cmd.y}) + CW'(w_row);
            end else if (w_retire) begin
                r_wvalid <= 1'b0;
            end
        end
    end

    assign bus.CMD_READY = w_cmd_ready;
    assign bus.ROM_RE    = w_issue;
    assign bus.ROM_ADDR  = w_rom_addr;
    assign bus.FB_WE     = w_we;
    assign bus.FB_PLANE  = w_we ? r_cmd.plane   : '0;
    assign bus.FB_X      = w_we ? r_px[8:0]     : '0;
    assign bus.FB_Y      = w_we ? r_py[8:0]     : '0;
    assign bus.FB_DATA   = w_we ? bus.ROM_DATA  : '0;
    assign bus.BUSY      = (r_state != IDLE);
    assign bus.DONE      = r_done;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: ROM model, write scoreboard, timing checks.
module tb_sprite_draw_engine;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    sprite_draw_engine_if bus ();

    sprite_draw_engine dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

`ifdef SPRITE_CLIP_EN
    localparam int N_EDGE = 64;
    localparam int N_WRAP = 0;
`else
    localparam int N_EDGE = 256;
    localparam int N_WRAP = 256;
`endif

    logic [3:0] rom [0:1023];
    always @(posedge Clk) if (bus.ROM_RE) bus.ROM_DATA <= rom[bus.ROM_ADDR];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit          active      = 1'b0;
    int          acc_cyc     = -100;
    int          acc_count   = 0;
    int          exp_done    = -1;
    int          nwr         = 0;
    int          exp_nwr     = 0;
    int          pend_nwr    = 0;
    bit          pend_stall  = 1'b0;
    int          stall_lo    = -10;
    int          stall_hi    = -10;
    int          rst_chk_cyc = -1;
    logic [1:0]  cur_id      = 2'd0;
    logic [23:0] prev_fb     = '0;
    logic [23:0] fb_now;
    logic [23:0] q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic build_q(input logic [1:0] plane, input logic [1:0] id,
                           input logic [8:0] x, input logic [8:0] y);
        q.delete();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int  px;
                int  py;
                bit  keep;
                logic [3:0] p;
                p  = rom[id * 256 + r * 16 + c];
                px = int'(x) + c;
                py = int'(y) + r;
`ifdef SPRITE_CLIP_EN
                keep = (px < 320) && (py < 240);
`else
                keep = 1'b1;
`endif
                if (p != 4'd0 && keep) q.push_back({plane, 9'(px), 9'(py), p});
            end
        end
    endtask

    // Samples the current cycle at negedge, then advances to just after the next posedge.
    task automatic step();
        @(negedge Clk);
        fb_now = {bus.FB_PLANE, bus.FB_X, bus.FB_Y, bus.FB_DATA};
        if (Reset) begin
            check("rst_ready", 32'(bus.CMD_READY), 0);
            q.delete();
            active = 1'b0;
        end else begin
            if (cyc == rst_chk_cyc) begin
                check("post_rst_ready", 32'(bus.CMD_READY), 1);
                check("post_rst_out", {bus.ROM_RE, bus.ROM_ADDR, bus.FB_WE, bus.BUSY, bus.DONE}, 0);
                check("post_rst_fb", 32'(fb_now), 0);
            end
            if (bus.FB_WE && bus.FB_READY) begin
                nwr++;
                if (q.size() == 0) check("wr_extra", 1, 0);
                else               check("wr", 32'(fb_now), 32'(q.pop_front()));
            end
            if (cyc >= stall_lo && cyc <= stall_hi) begin
                check("stall_we", 32'(bus.FB_WE), 1);
                check("stall_rom_re", 32'(bus.ROM_RE), 0);
            end
            if (cyc > stall_lo && cyc <= stall_hi + 1) check("stall_hold", 32'(fb_now), 32'(prev_fb));
            if (active && cyc == acc_cyc + 1)
                check("rd0", 32'({bus.BUSY, bus.ROM_RE, bus.ROM_ADDR}), 32'({2'b11, cur_id, 8'd0}));
            if (bus.DONE) begin
                if (!active) begin
                    check("done_spurious", 1, 0);
                end else begin
                    check("done_cyc", cyc, exp_done);
                    check("done_ready", 32'(bus.CMD_READY), 1);
                    check("nwr", nwr, exp_nwr);
                    check("q_left", q.size(), 0);
                end
                active = 1'b0;
            end
            if (bus.CMD_VALID && bus.CMD_READY) begin
                active   = 1'b1;
                acc_cyc  = cyc;
                cur_id   = bus.ID_CODE_IN;
                nwr      = 0;
                exp_nwr  = pend_nwr;
                exp_done = cyc + 258 + (pend_stall ? 3 : 0);
                if (pend_stall) begin
                    stall_lo = cyc + 2;
                    stall_hi = cyc + 4;
                end
                build_q(bus.ADDR_IN, bus.ID_CODE_IN, bus.X_IN, bus.Y_IN);
                acc_count++;
            end
        end
        prev_fb = fb_now;
        @(posedge Clk);
        #1;
        cyc++;
        bus.FB_READY = !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    task automatic drive_cmd(input logic [1:0] plane, input logic [1:0] id,
                             input logic [8:0] x, input logic [8:0] y,
                             input int nexp, input bit stall);
        bus.ADDR_IN    = plane;
        bus.ID_CODE_IN = id;
        bus.X_IN       = x;
        bus.Y_IN       = y;
        bus.CMD_VALID  = 1'b1;
        pend_nwr       = nexp;
        pend_stall     = stall;
    endtask

    task automatic wait_accept(input string name);
        int start;
        start = acc_count;
        for (int i = 0; i < 10 && acc_count == start; i++) step();
        if (acc_count == start) check({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && active; i++) step();
        if (active) begin
            check({name, "_done_timeout"}, 1, 0);
            active = 1'b0;
        end
    endtask

    task automatic run_cmd(input string name, input logic [1:0] plane, input logic [1:0] id,
                           input logic [8:0] x, input logic [8:0] y,
                           input int nexp, input bit stall);
        drive_cmd(plane, id, x, y, nexp, stall);
        wait_accept(name);
        bus.CMD_VALID = 1'b0;
        wait_idle(name);
        $display("cmd %s plane=%0d id=%0d x=%0d y=%0d writes=%0d", name, plane, id, x, y, nwr);
    endtask

    task automatic reset_mid();
        drive_cmd(2'd0, 2'd1, 9'd40, 9'd40, 256, 1'b0);
        wait_accept("rst_mid");
        bus.CMD_VALID = 1'b0;
        for (int i = 0; i < 60 && cyc < acc_cyc + 50; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        rst_chk_cyc = cyc;
        step();
        repeat (5) step();
        $display("cmd rst_mid aborted at cyc=%0d writes=%0d", rst_chk_cyc - 1, nwr);
    endtask

    // Chains B and C onto the DONE cycles of the previous command while
    // CMD_VALID stays high with junk fields in between.
    task automatic b2b();
        logic [1:0] pl [0:1];
        logic [1:0] id [0:1];
        logic [8:0] xs [0:1];
        logic [8:0] ys [0:1];
        int         ne [0:1];
        pl = '{2'd3, 2'd1};     id = '{2'd3, 2'd1};
        xs = '{9'd300, 9'd64};  ys = '{9'd220, 9'd64};
        ne = '{16, 256};
        drive_cmd(2'd2, 2'd2, 9'd5, 9'd5, 128, 1'b0);
        wait_accept("b2b_a");
        for (int k = 0; k < 2; k++) begin
            int prev_done;
            int start;
            prev_done = exp_done;
            start     = acc_count;
            for (int i = 0; i < 300 && acc_count == start; i++) begin
                if (cyc == prev_done) begin
                    drive_cmd(pl[k], id[k], xs[k], ys[k], ne[k], 1'b0);
                end else begin
                    bus.ADDR_IN    = 2'($urandom);
                    bus.ID_CODE_IN = 2'($urandom);
                    bus.X_IN       = 9'($urandom);
                    bus.Y_IN       = 9'($urandom);
                    bus.CMD_VALID  = 1'b1;
                end
                step();
            end
            check("b2b_accept_cyc", acc_cyc, prev_done);
            $display("cmd b2b_%0d accepted cyc=%0d", k, acc_cyc);
        end
        bus.CMD_VALID = 1'b0;
        wait_idle("b2b_c");
        $display("cmd b2b_c writes=%0d", nwr);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 16; c++) begin
                    logic [3:0] p;
                    case (i)
                        0:       p = 4'(((r * 3 + c) % 15) + 1);
                        1:       p = 4'd5;
                        2:       p = (((r ^ c) & 1) != 0) ? 4'd7 : 4'd0;
                        default: p = (r == c) ? 4'd9 : 4'd0;
                    endcase
                    rom[i * 256 + r * 16 + c] = p;
                end
            end
        end
        Reset          = 1'b1;
        bus.CMD_VALID  = 1'b0;
        bus.ADDR_IN    = '0;
        bus.ID_CODE_IN = '0;
        bus.X_IN       = '0;
        bus.Y_IN       = '0;
        bus.FB_READY   = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        rst_chk_cyc = cyc;
        step();

        run_cmd("opaque",   2'd2, 2'd1, 9'd10,  9'd20,  256,    1'b0);
        run_cmd("checker",  2'd1, 2'd2, 9'd100, 9'd50,  128,    1'b0);
        run_cmd("stall",    2'd3, 2'd1, 9'd0,   9'd0,   256,    1'b1);
        run_cmd("edge",     2'd0, 2'd0, 9'd312, 9'd232, N_EDGE, 1'b0);
        run_cmd("wrap",     2'd1, 2'd0, 9'd504, 9'd10,  N_WRAP, 1'b0);
        reset_mid();
        run_cmd("after_rst", 2'd2, 2'd3, 9'd200, 9'd100, 16,    1'b0);
        b2b();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
